// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit validation, 3-sample mid-bit majority vote.
// Bytes are offered on a req/ack handshake; framing and overrun errors are one-cycle pulses.
module uart_rx #(
    parameter int unsigned DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rxack,
    output logic       rxreq,
    output logic [7:0] rxdata,
    output logic       ferr,
    output logic       ovr
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_t;

    localparam logic [15:0] CntLast = 16'(DIV - 1);
    localparam logic [15:0] SmpA    = 16'(DIV / 2 - 1);
    localparam logic [15:0] SmpB    = 16'(DIV / 2);
    localparam logic [15:0] SmpC    = 16'(DIV / 2 + 1);

    state_t      state;
    logic        s1;
    logic        rs;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [2:0]  bitn;
    logic [7:0]  sh;
    logic [1:0]  smp;
    logic        vote;
    logic        dlv;
    logic        ferr_p;

    // cnt holds the count of the previous edge; cnt_n is the count at the current edge.
    always_comb begin
        cnt_n = (cnt == CntLast) ? 16'd0 : cnt + 16'd1;
        vote  = (smp[1] & smp[0]) | (smp[1] & rs) | (smp[0] & rs);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            s1     <= 1'b1;
            rs     <= 1'b1;
            cnt    <= 16'd0;
            bitn   <= 3'd0;
            sh     <= 8'h00;
            smp    <= 2'b00;
            dlv    <= 1'b0;
            ferr_p <= 1'b0;
            rxreq  <= 1'b0;
            rxdata <= 8'h00;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            s1     <= rx;
            rs     <= s1;
            dlv    <= 1'b0;
            ferr_p <= 1'b0;
            ferr   <= ferr_p;
            ovr    <= 1'b0;

            // Delivery lags the stop-bit decision by one edge; an ack on that edge
            // lets the new byte replace the held one.
            if (dlv) begin
                if (!rxreq || rxack) begin
                    rxdata <= sh;
                    rxreq  <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (rxreq && rxack) begin
                rxreq <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (!rs) begin
                        state <= StStart;
                        cnt   <= 16'd0;
                        bitn  <= 3'd0;
                    end
                end
                StStart, StData, StStop: begin
                    cnt <= cnt_n;
                    if (cnt_n == SmpA) smp[0] <= rs;
                    if (cnt_n == SmpB) smp[1] <= rs;
                    if (cnt_n == SmpC) begin
                        if (state == StStart) begin
                            state <= vote ? StIdle : StData;
                        end else if (state == StData) begin
                            sh   <= {vote, sh[7:1]};
                            bitn <= bitn + 3'd1;
                            if (bitn == 3'd7) state <= StStop;
                        end else begin
                            dlv    <= vote;
                            ferr_p <= ~vote;
                            state  <= vote ? StIdle : StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (rs) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Standalone 8N1 UART receiver that turns the asynchronous serial line into bytes on the same req/ack byte handshake used by the transmit side of the UART. It sits between the board RX pin and any byte consumer (command parser, FIFO, debug bridge). The line is synchronized, the start bit is validated, and each bit is majority-voted at mid-bit. Framing and overrun errors are reported as one-cycle pulses.

## Interface
- DIV, 16: clocks per bit period; legal range 8..65535.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line; asynchronous; idles high.
- rxreq  out  1  byte available; held until acknowledged.
- rxack  in  1  consumer accepts the byte; sampled only while rxreq=1.
- rxdata  out  8  received byte; stable while rxreq=1.
- ferr  out  1  one-cycle pulse: stop bit sampled 0; byte discarded.
- ovr  out  1  one-cycle pulse: byte completed while the previous byte was still unacknowledged; new byte discarded.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Synchronizer: rx passes through 2 flops that reset to 1. rs denotes the synchronized value.
- State machine:
  - IDLE: on rs=0, go to START and clear the bit counter and the clock counter.
  - START: majority-vote the start bit. Result 1 (glitch): go to IDLE with no output. Result 0: go to DATA.
  - DATA: shift the voted bit into the shift register MSB, so it ends up LSB first after 8 bits. After the 8th bit, go to STOP.
  - STOP: vote the stop bit.
    - 1: deliver the byte, then go to IDLE.
    - 0: pulse ferr, then go to BREAK.
  - BREAK: wait for rs=1, then go to IDLE. No start detection happens in BREAK.
- Voting: 3 samples at clock counts DIV/2-1, DIV/2 and DIV/2+1 within the bit, using integer division. The majority (≥2 ones) is the bit value. The clock counter is 16 bits wide and wraps 0..DIV-1 each bit.
- Delivery:
  - rxreq=0: rxdata takes the shift register and rxreq goes to 1.
  - rxreq=1 with rxack=1 in the same cycle: the byte is accepted as a replacement. rxdata is updated and rxreq stays 1. No ovr.
  - rxreq=1 with rxack=0: pulse ovr. rxdata is unchanged.
- Handshake: rxack=1 at a rising edge while rxreq=1 makes rxreq=0 on the next cycle, unless a replacement is delivered in that same edge. rxack while rxreq=0 is ignored.
- Return to IDLE happens at mid-stop bit. Back-to-back frames with no idle gap are received without loss.

## Timing
- Reset values:
  - rxreq=0, rxdata=8'h00, ferr=0, ovr=0.
  - State IDLE; synchronizer flops 1; all counters 0.
- Reset asserted mid-frame aborts the frame immediately, with no ferr or ovr. After release, the receiver waits in IDLE for a falling edge.
- Let t0 be the edge at which IDLE sees rs=0. This is 2–3 cycles after the pin falls.
- Bit k (0=start, 1..8 data, 9=stop) is voted at edges t0 + k·DIV + DIV/2 ± 1. The decision is made at the last sample.
- Outputs appear one edge after the stop-bit decision:
  - rxreq rises, and rxdata is valid, at t0 + 9·DIV + DIV/2 + 2.
  - ferr and ovr pulse at that same edge.
- Start-glitch rejection: a low pulse shorter than about DIV/2-1 clocks yields no rxreq and no ferr.
- Tolerated baud mismatch: ±4% at DIV ≥ 16.

## Test plan
- Clean byte, DIV=16, 8'hA5 sent at exact rate, rxack tied 0:
  - rxreq rises at t0+154 with rxdata=8'hA5.
  - ferr=0, ovr=0.
  - rxreq stays high.
- Back-to-back stream 8'h00, 8'hFF, 8'h55 with no idle gap; consumer acks 1 cycle after each rxreq: 3 rxreq events carrying 00, FF, 55, with no errors.
- Glitch: rx low for 4 cycles, then high: no rxreq, no ferr; the state returns to IDLE.
- Framing error: 8'h3C sent with stop bit 0, followed by 30 more low cycles, then a valid 8'h81:
  - one ferr pulse;
  - no rxreq for 3C;
  - the 81 frame after the line goes high is received correctly.
- Overrun: 8'h11 then 8'h22 sent, no ack: rxdata stays 11 and ovr pulses once at the completion of 22. Variant with ack asserted exactly on the completion edge of 22: rxdata becomes 22, rxreq stays 1, and there is no ovr.
- Async reset asserted during data bit 4 of a frame: outputs read 0 immediately. The next full frame 8'h7E after reset release is received with no error.
